// File: rtl/rst_seq.sv
// Reset sequencer: button synchronizer/debounce, then a staged release (peripheral, then core).
// Optional cause register enabled by defining RST_SEQ_CAUSE_EN.
module rst_seq #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int PERIPH_HOLD     = 32,
  parameter int CORE_DELAY      = 16
) (
  input  logic       clk_sys,
  input  logic       rst_sys,
  input  logic       ext_rst_ni,
  input  logic       soft_rst_req_i,
  output logic       rst_periph_n,
  output logic       rst_core_n,
  output logic       sys_ready_o,
  output logic [1:0] rst_cause_o
);

  localparam int MAX_HOLD = (PERIPH_HOLD > CORE_DELAY) ? PERIPH_HOLD : CORE_DELAY;
  localparam int CNT_W    = $clog2(MAX_HOLD + 1);
  localparam int DB_W     = $clog2(DEBOUNCE_CYCLES + 1);

  typedef enum logic [2:0] {
    ST_RESET,
    ST_WAIT_BTN,
    ST_HOLD_PERIPH,
    ST_HOLD_CORE,
    ST_RUN
  } state_t;

  logic [SYNC_STAGES-1:0] r_sync;
  logic [DB_W-1:0]        r_db_cnt;
  logic                   r_btn_filt;
  logic                   w_sample_press;
  logic                   w_btn_press;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [CNT_W-1:0]       r_cnt;
  logic [CNT_W-1:0]       w_cnt_nxt;
  logic                   r_periph_n, w_periph_nxt;
  logic                   r_core_n,   w_core_nxt;
  logic                   r_ready,    w_ready_nxt;

  // Button synchronizer; idles high (released) out of reset
  always_ff @(posedge clk_sys) begin
    if (rst_sys) begin
      r_sync <= '1;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], ext_rst_ni};
    end
  end

  assign w_sample_press = ~r_sync[SYNC_STAGES-1];

  // Debounce: flip the filtered state only after a full run of disagreeing samples
  always_ff @(posedge clk_sys) begin
    if (rst_sys) begin
      r_db_cnt   <= '0;
      r_btn_filt <= 1'b0;
    end else if (w_sample_press == r_btn_filt) begin
      r_db_cnt   <= '0;
    end else if (r_db_cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
      r_db_cnt   <= '0;
      r_btn_filt <= w_sample_press;
    end else begin
      r_db_cnt   <= r_db_cnt + 1'b1;
    end
  end

  assign w_btn_press = r_btn_filt;

  always_ff @(posedge clk_sys) begin
    if (rst_sys) begin
      r_state    <= ST_RESET;
      r_cnt      <= '0;
      r_periph_n <= 1'b0;
      r_core_n   <= 1'b0;
      r_ready    <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_periph_n <= w_periph_nxt;
      r_core_n   <= w_core_nxt;
      r_ready    <= w_ready_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_periph_nxt = r_periph_n;
    w_core_nxt   = r_core_n;
    w_ready_nxt  = r_ready;
    case (r_state)
      ST_RESET: begin
        w_state_nxt  = ST_WAIT_BTN;
        w_cnt_nxt    = '0;
        w_periph_nxt = 1'b0;
        w_core_nxt   = 1'b0;
        w_ready_nxt  = 1'b0;
      end
      ST_WAIT_BTN: begin
        w_periph_nxt = 1'b0;
        w_core_nxt   = 1'b0;
        w_ready_nxt  = 1'b0;
        if (!w_btn_press) begin
          w_state_nxt = ST_HOLD_PERIPH;
          w_cnt_nxt   = '0;
        end
      end
      ST_HOLD_PERIPH, ST_HOLD_CORE, ST_RUN: begin
        // Button outranks the soft request; either one drops both resets at once
        if (w_btn_press || soft_rst_req_i) begin
          w_state_nxt  = w_btn_press ? ST_WAIT_BTN : ST_HOLD_PERIPH;
          w_cnt_nxt    = '0;
          w_periph_nxt = 1'b0;
          w_core_nxt   = 1'b0;
          w_ready_nxt  = 1'b0;
        end else if (r_state == ST_HOLD_PERIPH) begin
          if (r_cnt == CNT_W'(PERIPH_HOLD - 1)) begin
            w_state_nxt  = ST_HOLD_CORE;
            w_cnt_nxt    = '0;
            w_periph_nxt = 1'b1;
          end else begin
            w_cnt_nxt    = r_cnt + 1'b1;
          end
        end else if (r_state == ST_HOLD_CORE) begin
          if (r_cnt == CNT_W'(CORE_DELAY - 1)) begin
            w_state_nxt  = ST_RUN;
            w_cnt_nxt    = '0;
            w_core_nxt   = 1'b1;
            w_ready_nxt  = 1'b1;
          end else begin
            w_cnt_nxt    = r_cnt + 1'b1;
          end
        end
      end
      default: begin
        w_state_nxt  = ST_RESET;
        w_cnt_nxt    = '0;
        w_periph_nxt = 1'b0;
        w_core_nxt   = 1'b0;
        w_ready_nxt  = 1'b0;
      end
    endcase
  end

  assign rst_periph_n = r_periph_n;
  assign rst_core_n   = r_core_n;
  assign sys_ready_o  = r_ready;

`ifdef RST_SEQ_CAUSE_EN
  logic [1:0] r_cause;
  logic       w_active;

  assign w_active = (r_state == ST_HOLD_PERIPH) || (r_state == ST_HOLD_CORE) ||
                    (r_state == ST_RUN);

  always_ff @(posedge clk_sys) begin
    if (rst_sys) begin
      r_cause <= 2'b00;
    end else if (w_active && w_btn_press) begin
      r_cause <= 2'b01;
    end else if (w_active && soft_rst_req_i) begin
      r_cause <= 2'b10;
    end
  end

  assign rst_cause_o = r_cause;
`else
  assign rst_cause_o = 2'b00;
`endif

  a_core_implies_periph : assert property (@(posedge clk_sys) disable iff (rst_sys)
    !(rst_core_n && !rst_periph_n));

endmodule

// File: tb/tb_rst_seq.sv
// Bench for rst_seq: directed timing checks plus randomized traffic scored against a
// cycle-level behavioural model (sequence age, sample windows) through an expectation queue.
module tb_rst_seq;

  localparam int SYNC = 2;
  localparam int DEB  = 16;
  localparam int PH   = 32;
  localparam int CD   = 16;

  logic       clk_sys = 1'b0;
  logic       rst_sys;
  logic       ext_rst_ni;
  logic       soft_rst_req_i;
  logic       rst_periph_n;
  logic       rst_core_n;
  logic       sys_ready_o;
  logic [1:0] rst_cause_o;

  int n_checks = 0;
  int n_errors = 0;

  rst_seq #(
    .SYNC_STAGES    (SYNC),
    .DEBOUNCE_CYCLES(DEB),
    .PERIPH_HOLD    (PH),
    .CORE_DELAY     (CD)
  ) dut (
    .clk_sys        (clk_sys),
    .rst_sys        (rst_sys),
    .ext_rst_ni     (ext_rst_ni),
    .soft_rst_req_i (soft_rst_req_i),
    .rst_periph_n   (rst_periph_n),
    .rst_core_n     (rst_core_n),
    .sys_ready_o    (sys_ready_o),
    .rst_cause_o    (rst_cause_o)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    bit       p;
    bit       c;
    bit       r;
    bit [1:0] cause;
  } exp_t;

  exp_t exp_q[$];

  int       m_stage = 0;   // 0: in reset, 1: waiting for button release, 2: sequence running
  int       m_age   = 0;   // edges since the current sequence started
  bit       m_filt  = 0;   // debounced "pressed"
  bit       m_pins[$];     // pin history, newest first, SYNC entries deep
  bit       m_win[$];      // recent debounce samples, oldest first, at most DEB entries
  bit [1:0] m_cause = 2'b00;

  task automatic model_step();
    exp_t e;
    bit   btn;
    bit   samp;
    bit   all_diff;
    if (rst_sys) begin
      m_stage = 0;
      m_age   = 0;
      m_filt  = 0;
      m_pins  = {};
      for (int i = 0; i < SYNC; i++) m_pins.push_back(1'b1);
      m_win   = {};
      m_cause = 2'b00;
    end else begin
      btn  = m_filt;
      samp = !m_pins[SYNC-1];
      if (m_stage == 0) begin
        m_stage = 1;
      end else if (m_stage == 1) begin
        if (!btn) begin
          m_stage = 2;
          m_age   = 0;
        end
      end else begin
        if (btn) begin
          m_stage = 1;
          m_cause = 2'b01;
        end else if (soft_rst_req_i) begin
          m_age   = 0;
          m_cause = 2'b10;
        end else if (m_age < 100000) begin
          m_age++;
        end
      end
      m_win.push_back(samp);
      if (m_win.size() > DEB) void'(m_win.pop_front());
      if (m_win.size() == DEB) begin
        all_diff = 1'b1;
        foreach (m_win[k]) if (m_win[k] == m_filt) all_diff = 1'b0;
        if (all_diff) m_filt = !m_filt;
      end
      m_pins.push_front(ext_rst_ni);
      void'(m_pins.pop_back());
    end
    e.p = (m_stage == 2) && (m_age >= PH);
    e.c = (m_stage == 2) && (m_age >= PH + CD);
    e.r = e.c;
`ifdef RST_SEQ_CAUSE_EN
    e.cause = m_cause;
`else
    e.cause = 2'b00;
`endif
    exp_q.push_back(e);
  endtask

  initial begin
    forever begin
      @(posedge clk_sys);
      model_step();
    end
  end

  // Monitor: compares every presented cycle against the queued expectation
  initial begin
    exp_t e;
    forever begin
      @(negedge clk_sys);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("sb_periph", int'(rst_periph_n), int'(e.p));
        check("sb_core",   int'(rst_core_n),   int'(e.c));
        check("sb_ready",  int'(sys_ready_o),  int'(e.r));
        check("sb_cause",  int'(rst_cause_o),  int'(e.cause));
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk_sys);
      #1;
    end
  endtask

  // Edge index 'start' is the next edge; returns first indices where periph/core are high
  task automatic measure(input int start, input int budget, output int tp, output int tc);
    tp = -1;
    tc = -1;
    for (int i = start; i < budget; i++) begin
      tick(1);
      if (tp < 0 && rst_periph_n) tp = i;
      if (tc < 0 && rst_core_n)   tc = i;
      if (tc >= 0) break;
    end
  endtask

  task automatic check_cause(input string name, input int exp);
`ifdef RST_SEQ_CAUSE_EN
    check(name, int'(rst_cause_o), exp);
`else
    check(name, int'(rst_cause_o), 0);
`endif
  endtask

  initial begin
    int tp, tc, tf, drops;
    rst_sys        = 1'b1;
    ext_rst_ni     = 1'b1;
    soft_rst_req_i = 1'b0;

    // Power-on
    tick(3);
    check("rst_periph", int'(rst_periph_n), 0);
    check("rst_core",   int'(rst_core_n),   0);
    check("rst_ready",  int'(sys_ready_o),  0);
    check("rst_cause",  int'(rst_cause_o),  0);
    rst_sys = 1'b0;
    measure(0, 120, tp, tc);
    check("por_periph_edge", tp, PH + 1);
    check("por_core_edge",   tc, PH + CD + 1);
    check("por_ready",       int'(sys_ready_o), 1);

    // Soft reset from ST_RUN
    tick(5);
    soft_rst_req_i = 1'b1;
    tick(1);
    soft_rst_req_i = 1'b0;
    check("soft_periph_low", int'(rst_periph_n), 0);
    check("soft_core_low",   int'(rst_core_n),   0);
    measure(1, 120, tp, tc);
    check("soft_periph_edge", tp, PH);
    check("soft_core_edge",   tc, PH + CD);
    check_cause("soft_cause", 2);

    // Short glitch must be ignored
    ext_rst_ni = 1'b0;
    tick(10);
    ext_rst_ni = 1'b1;
    drops = 0;
    for (int i = 0; i < 40; i++) begin
      tick(1);
      if (!sys_ready_o || !rst_periph_n || !rst_core_n) drops++;
    end
    check("glitch_drops", drops, 0);

    // Long press: fall latency, hold, release sequence
    ext_rst_ni = 1'b0;
    tf = -1;
    for (int i = 0; i < 40; i++) begin
      tick(1);
      if (!rst_periph_n) begin
        tf = i;
        break;
      end
    end
    check("btn_fall_edge", tf, SYNC + DEB);
    tick(100 - (SYNC + DEB + 1));
    check("btn_held_low", int'(rst_periph_n), 0);
    ext_rst_ni = 1'b1;
    measure(0, 150, tp, tc);
    check("btn_rel_periph_edge", tp, SYNC + DEB + PH);
    check("btn_rel_core_edge",   tc, SYNC + DEB + PH + CD);
    check_cause("btn_cause", 1);

    // Soft request with the core-delay counter at 7
    soft_rst_req_i = 1'b1;
    tick(1);
    soft_rst_req_i = 1'b0;
    tp = -1;
    for (int i = 1; i < 60; i++) begin
      tick(1);
      if (rst_periph_n) begin
        tp = i;
        break;
      end
    end
    check("mid_periph_edge", tp, PH);
    tick(7);
    soft_rst_req_i = 1'b1;
    tick(1);
    soft_rst_req_i = 1'b0;
    check("mid_restart_low", int'(rst_periph_n), 0);
    measure(1, 120, tp, tc);
    check("mid_periph_edge2", tp, PH);
    check("mid_core_edge2",   tc, PH + CD);

    // Button and soft request in the same cycle, then rst_sys mid ST_HOLD_PERIPH
    ext_rst_ni = 1'b0;
    tick(SYNC + DEB);
    soft_rst_req_i = 1'b1;
    tick(1);
    soft_rst_req_i = 1'b0;
    check("both_periph_low", int'(rst_periph_n), 0);
    check_cause("both_cause", 1);
    ext_rst_ni = 1'b1;
    tick(SYNC + DEB + 6);
    check("both_still_holding", int'(rst_periph_n), 0);
    rst_sys = 1'b1;
    tick(1);
    check("midrst_periph", int'(rst_periph_n), 0);
    check("midrst_ready",  int'(sys_ready_o),  0);
    check("midrst_cause",  int'(rst_cause_o),  0);
    tick(2);
    rst_sys = 1'b0;
    measure(0, 120, tp, tc);
    check("por2_periph_edge", tp, PH + 1);
    check("por2_core_edge",   tc, PH + CD + 1);

    // Randomized traffic, checked by the scoreboard
    for (int it = 0; it < 60; it++) begin
      case ($urandom_range(0, 5))
        0: tick($urandom_range(1, 60));
        1: begin
          soft_rst_req_i = 1'b1;
          tick(1);
          soft_rst_req_i = 1'b0;
          tick($urandom_range(1, 40));
        end
        2: begin
          ext_rst_ni = 1'b0;
          tick($urandom_range(1, DEB - 1));
          ext_rst_ni = 1'b1;
          tick($urandom_range(1, 30));
        end
        3: begin
          ext_rst_ni = 1'b0;
          tick($urandom_range(DEB + 1, 80));
          ext_rst_ni = 1'b1;
          tick($urandom_range(1, 70));
        end
        4: begin
          rst_sys = 1'b1;
          tick($urandom_range(1, 3));
          rst_sys = 1'b0;
          tick($urandom_range(1, 60));
        end
        default: begin
          ext_rst_ni = 1'b0;
          tick($urandom_range(1, 30));
          soft_rst_req_i = 1'b1;
          tick(1);
          soft_rst_req_i = 1'b0;
          tick($urandom_range(1, 30));
          ext_rst_ni = 1'b1;
          tick($urandom_range(1, 60));
        end
      endcase
    end

    tick(2);
    @(negedge clk_sys);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
